// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: requester handshake and SPIMaster control bundle.
// master = arbiter side, slave = requesters plus SPIMaster side.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int SS_WIDTH = 32
);
    logic [NUM_REQ-1:0]    req_i;
    logic [32*NUM_REQ-1:0] req_wdata_i;
    logic [3*NUM_REQ-1:0]  req_bytes_i;
    logic [5*NUM_REQ-1:0]  req_ss_idx_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [NUM_REQ-1:0]    done_o;
    logic                  err_o;
    logic [31:0]           rdata_o;
    logic                  busy_o;
    logic                  spi_enable_o;
    logic [31:0]           spi_wdata_o;
    logic [2:0]            spi_bytes_o;
    logic                  spi_reset_fill_level_o;
    logic [31:0]           spi_rdata_i;
    logic [2:0]            spi_rbytes_valid_i;
    logic [SS_WIDTH-1:0]   spi_ss_o;

    modport master (
        input  req_i, req_wdata_i, req_bytes_i, req_ss_idx_i,
        input  spi_rdata_i, spi_rbytes_valid_i,
        output gnt_o, done_o, err_o, rdata_o, busy_o,
        output spi_enable_o, spi_wdata_o, spi_bytes_o,
        output spi_reset_fill_level_o, spi_ss_o
    );

    modport slave (
        output req_i, req_wdata_i, req_bytes_i, req_ss_idx_i,
        output spi_rdata_i, spi_rbytes_valid_i,
        input  gnt_o, done_o, err_o, rdata_o, busy_o,
        input  spi_enable_o, spi_wdata_o, spi_bytes_o,
        input  spi_reset_fill_level_o, spi_ss_o
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPIMaster between
// NUM_REQ requesters, with select timing, enable sequencing and timeout.
module spi_txn_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int SS_WIDTH        = 32,
    parameter int SS_ACTIVE_HIGH  = 0,
    parameter int SS_SETUP_CYCLES = 2,
    parameter int SS_HOLD_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    spi_txn_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (SS_SETUP_CYCLES > SS_HOLD_CYCLES)
                           ? SS_SETUP_CYCLES : SS_HOLD_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SS_WIDTH-1:0] SS_IDLE = (SS_ACTIVE_HIGH != 0)
        ? {SS_WIDTH{1'b0}} : {SS_WIDTH{1'b1}};
    localparam logic [SS_WIDTH-1:0] SS_ONE =
        {{(SS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] REQ_ONE =
        {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SS_HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_err;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  tcnt;

    logic [IDX_W-1:0] probe;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [31:0]      win_wdata;
    logic [2:0]       win_bytes;
    logic [4:0]       win_ss;
    logic             ss_ok;
    logic             win_ok;

    // Round-robin search starting one past the last owner.
    always_comb begin
        probe     = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            probe = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
            if (!win_found && bus.req_i[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    // Winner field selection and request validation.
    always_comb begin
        win_wdata = bus.req_wdata_i[32*win_idx +: 32];
        win_bytes = bus.req_bytes_i[3*win_idx +: 3];
        win_ss    = bus.req_ss_idx_i[5*win_idx +: 5];
        win_ok    = (win_bytes != 3'd0) && (win_bytes <= 3'd4) && ss_ok;
    end

    // A 5-bit index can only overflow a select bus narrower than 32.
    if (SS_WIDTH >= 32) begin : g_ss_full
        assign ss_ok = 1'b1;
    end else begin : g_ss_part
        assign ss_ok = (win_ss < 5'(SS_WIDTH));
    end

    // Transfer sequencer; every output is a register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                      <= S_IDLE;
            last_gnt                   <= IDX_LAST;
            cur_idx                    <= '0;
            cur_err                    <= 1'b0;
            cnt                        <= '0;
            tcnt                       <= '0;
            bus.gnt_o                  <= '0;
            bus.done_o                 <= '0;
            bus.err_o                  <= 1'b0;
            bus.rdata_o                <= '0;
            bus.busy_o                 <= 1'b0;
            bus.spi_enable_o           <= 1'b0;
            bus.spi_wdata_o            <= '0;
            bus.spi_bytes_o            <= '0;
            bus.spi_reset_fill_level_o <= 1'b0;
            bus.spi_ss_o               <= SS_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cur_idx         <= win_idx;
                        cur_err         <= !win_ok;
                        cnt             <= '0;
                        bus.gnt_o       <= REQ_ONE << win_idx;
                        bus.busy_o      <= 1'b1;
                        bus.spi_wdata_o <= win_wdata;
                        bus.spi_bytes_o <= win_bytes;
                        if (win_ok) begin
                            bus.spi_ss_o <= SS_IDLE ^ (SS_ONE << win_ss);
                        end
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cur_err) begin
                        bus.done_o                 <= REQ_ONE << cur_idx;
                        bus.err_o                  <= 1'b1;
                        bus.spi_reset_fill_level_o <= 1'b1;
                        bus.spi_ss_o               <= SS_IDLE;
                        state                      <= S_DONE;
                    end else if (cnt == SETUP_LAST) begin
                        cnt              <= '0;
                        tcnt             <= '0;
                        bus.spi_enable_o <= 1'b1;
                        state            <= S_XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (bus.spi_rbytes_valid_i == bus.spi_bytes_o) begin
                        bus.rdata_o      <= bus.spi_rdata_i;
                        bus.spi_enable_o <= 1'b0;
                        cnt              <= '0;
                        state            <= S_HOLD;
                    end else if (tcnt == TO_LAST) begin
                        bus.spi_enable_o <= 1'b0;
                        cur_err          <= 1'b1;
                        cnt              <= '0;
                        state            <= S_HOLD;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        bus.done_o                 <= REQ_ONE << cur_idx;
                        bus.err_o                  <= cur_err;
                        bus.spi_reset_fill_level_o <= 1'b1;
                        bus.spi_ss_o               <= SS_IDLE;
                        state                      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    bus.done_o                 <= '0;
                    bus.err_o                  <= 1'b0;
                    bus.spi_reset_fill_level_o <= 1'b0;
                    bus.gnt_o                  <= '0;
                    bus.busy_o                 <= 1'b0;
                    last_gnt                   <= cur_idx;
                    state                      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed bench with a done-ordered scoreboard
// and behavioural SPIMaster models for two arbiter configurations.
module tb_spi_txn_arbiter;
    typedef struct {
        int          req;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.NUM_REQ(4), .SS_WIDTH(32)) ifa ();
    spi_txn_arbiter_if #(.NUM_REQ(4), .SS_WIDTH(16)) ifb ();

    spi_txn_arbiter #(
        .NUM_REQ(4), .SS_WIDTH(32), .SS_ACTIVE_HIGH(0),
        .SS_SETUP_CYCLES(2), .SS_HOLD_CYCLES(2), .TIMEOUT_CYCLES(4096)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa.master)
    );

    spi_txn_arbiter #(
        .NUM_REQ(4), .SS_WIDTH(16), .SS_ACTIVE_HIGH(1),
        .SS_SETUP_CYCLES(2), .SS_HOLD_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb.master)
    );

    int n_assert = 0;
    int n_fail = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea;
    exp_t eb;

    int lat_a = 3;
    int lat_b = 2;
    int ena_a = 0;
    int ena_b = 0;
    logic stuck_b = 1'b0;
    logic [31:0] mask_a = 32'h0F0F_0F0F;
    logic [31:0] mask_b = 32'h3C3C_3C3C;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req_a(input int k, input logic [31:0] wd,
                             input logic [2:0] nb, input logic [4:0] ss);
        ifa.req_wdata_i[32*k +: 32] = wd;
        ifa.req_bytes_i[3*k +: 3]   = nb;
        ifa.req_ss_idx_i[5*k +: 5]  = ss;
    endtask

    task automatic set_req_b(input int k, input logic [31:0] wd,
                             input logic [2:0] nb, input logic [4:0] ss);
        ifb.req_wdata_i[32*k +: 32] = wd;
        ifb.req_bytes_i[3*k +: 3]   = nb;
        ifb.req_ss_idx_i[5*k +: 5]  = ss;
    endtask

    task automatic push_a(input int k, input logic e,
                          input logic [31:0] rd, input logic c);
        exp_t x;
        x.req = k; x.err = e; x.rdata = rd; x.chk_rd = c;
        sb_a.push_back(x);
    endtask

    task automatic push_b(input int k, input logic e,
                          input logic [31:0] rd, input logic c);
        exp_t x;
        x.req = k; x.err = e; x.rdata = rd; x.chk_rd = c;
        sb_b.push_back(x);
    endtask

    // Wait (bounded) for a done pulse; report cycles waited and enable cycles.
    task automatic run(input bit b, input int bound,
                       output int cyc, output int en);
        logic found;
        found = 1'b0;
        cyc = 0;
        en = 0;
        while (!found && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (b ? ifb.spi_enable_o : ifa.spi_enable_o) en++;
            if (b ? (ifb.done_o != 0) : (ifa.done_o != 0)) found = 1'b1;
        end
        chk(b ? "run_b_done_seen" : "run_a_done_seen", found, 1'b1);
    endtask

    // SPIMaster model A: fills after lat_a enable cycles.
    always @(posedge clk) begin
        if (rst || ifa.spi_reset_fill_level_o) begin
            ena_a <= 0;
            ifa.spi_rbytes_valid_i <= 3'd0;
            ifa.spi_rdata_i <= 32'd0;
        end else if (ifa.spi_enable_o) begin
            ena_a <= ena_a + 1;
            if (ena_a + 1 == lat_a) begin
                ifa.spi_rbytes_valid_i <= ifa.spi_bytes_o;
                ifa.spi_rdata_i <= ifa.spi_wdata_o ^ mask_a;
            end
        end
    end

    // SPIMaster model B: optionally stuck at a partial fill of 2.
    always @(posedge clk) begin
        if (rst) begin
            ena_b <= 0;
            ifb.spi_rbytes_valid_i <= 3'd0;
            ifb.spi_rdata_i <= 32'd0;
        end else if (stuck_b) begin
            ifb.spi_rbytes_valid_i <= 3'd2;
        end else if (ifb.spi_reset_fill_level_o) begin
            ena_b <= 0;
            ifb.spi_rbytes_valid_i <= 3'd0;
        end else if (ifb.spi_enable_o) begin
            ena_b <= ena_b + 1;
            if (ena_b + 1 == lat_b) begin
                ifb.spi_rbytes_valid_i <= ifb.spi_bytes_o;
                ifb.spi_rdata_i <= ifb.spi_wdata_o ^ mask_b;
            end
        end
    end

    // Scoreboard check for arbiter A completions.
    always @(negedge clk) begin
        if (!rst && ifa.done_o != 4'd0) begin
            if (sb_a.size() == 0) begin
                chk("sb_a_unexpected_done", ifa.done_o, 32'd0);
            end else begin
                ea = sb_a.pop_front();
                chk("sb_a_done", ifa.done_o, 32'd1 << ea.req);
                chk("sb_a_err", ifa.err_o, ea.err);
                chk("sb_a_fill", ifa.spi_reset_fill_level_o, 1'b1);
                if (ea.chk_rd) chk("sb_a_rdata", ifa.rdata_o, ea.rdata);
            end
        end
    end

    // Scoreboard check for arbiter B completions.
    always @(negedge clk) begin
        if (!rst && ifb.done_o != 4'd0) begin
            if (sb_b.size() == 0) begin
                chk("sb_b_unexpected_done", ifb.done_o, 32'd0);
            end else begin
                eb = sb_b.pop_front();
                chk("sb_b_done", ifb.done_o, 32'd1 << eb.req);
                chk("sb_b_err", ifb.err_o, eb.err);
                chk("sb_b_fill", ifb.spi_reset_fill_level_o, 1'b1);
                if (eb.chk_rd) chk("sb_b_rdata", ifb.rdata_o, eb.rdata);
            end
        end
    end

    initial begin
        int cyc;
        int en;
        logic [2:0] bad_bytes [3];
        logic [31:0] exp_ss;
        bad_bytes[0] = 3'd0;
        bad_bytes[1] = 3'd5;
        bad_bytes[2] = 3'd7;

        ifa.req_i = '0;
        ifa.req_wdata_i = '0;
        ifa.req_bytes_i = '0;
        ifa.req_ss_idx_i = '0;
        ifb.req_i = '0;
        ifb.req_wdata_i = '0;
        ifb.req_bytes_i = '0;
        ifb.req_ss_idx_i = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_gnt", ifa.gnt_o, 32'd0);
        chk("rst_done", ifa.done_o, 32'd0);
        chk("rst_err", ifa.err_o, 1'b0);
        chk("rst_busy", ifa.busy_o, 1'b0);
        chk("rst_enable", ifa.spi_enable_o, 1'b0);
        chk("rst_fill", ifa.spi_reset_fill_level_o, 1'b0);
        chk("rst_rdata", ifa.rdata_o, 32'd0);
        chk("rst_wdata", ifa.spi_wdata_o, 32'd0);
        chk("rst_bytes", ifa.spi_bytes_o, 32'd0);
        chk("rst_ss_a", ifa.spi_ss_o, 32'hFFFF_FFFF);
        chk("rst_ss_b", ifb.spi_ss_o, 32'd0);

        // Single transfer: requester 2, 4 bytes, slave 5.
        lat_a = 40;
        mask_a = 32'hA5A5_1234 ^ 32'hDEAD_BEEF;
        set_req_a(2, 32'hA5A5_1234, 3'd4, 5'd5);
        push_a(2, 1'b0, 32'hDEAD_BEEF, 1'b1);
        ifa.req_i = 4'b0100;
        @(negedge clk);
        chk("t1_gnt_c1", ifa.gnt_o, 32'h4);
        chk("t1_ss_c1", ifa.spi_ss_o, 32'hFFFF_FFDF);
        chk("t1_en_c1", ifa.spi_enable_o, 1'b0);
        chk("t1_busy_c1", ifa.busy_o, 1'b1);
        ifa.req_i = '0;
        @(negedge clk);
        chk("t1_en_c2", ifa.spi_enable_o, 1'b0);
        chk("t1_ss_c2", ifa.spi_ss_o, 32'hFFFF_FFDF);
        @(negedge clk);
        chk("t1_en_c3", ifa.spi_enable_o, 1'b1);
        chk("t1_wdata", ifa.spi_wdata_o, 32'hA5A5_1234);
        chk("t1_bytes", ifa.spi_bytes_o, 32'd4);
        run(0, 100, cyc, en);
        chk("t1_done_cycle", 3 + cyc, 46);
        chk("t1_en_cycles", en + 1, 41);
        chk("t1_ss_done", ifa.spi_ss_o, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t1_idle_busy", ifa.busy_o, 1'b0);
        chk("t1_idle_gnt", ifa.gnt_o, 32'd0);
        chk("t1_idle_done", ifa.done_o, 32'd0);

        // Round-robin with all four requesting from reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lat_a = 3;
        mask_a = 32'h0F0F_0F0F;
        for (int k = 0; k < 4; k++) begin
            set_req_a(k, 32'h1111_1111 * (k + 1), 3'(k + 1), 5'(k + 3));
        end
        for (int t = 0; t < 5; t++) begin
            push_a(t % 4, 1'b0,
                   (32'h1111_1111 * ((t % 4) + 1)) ^ 32'h0F0F_0F0F, 1'b1);
        end
        ifa.req_i = 4'b1111;
        @(negedge clk);
        chk("rr_gnt_first", ifa.gnt_o, 32'h1);
        for (int t = 0; t < 5; t++) begin
            run(0, 100, cyc, en);
            if (t == 4) ifa.req_i = '0;
            @(negedge clk);
            chk("rr_gap_busy", ifa.busy_o, 1'b0);
            chk("rr_gap_gnt", ifa.gnt_o, 32'd0);
            if (t < 4) begin
                @(negedge clk);
                chk("rr_gnt_next", ifa.gnt_o, 32'd1 << ((t + 1) % 4));
            end
        end

        // Invalid byte counts are rejected without touching the bus.
        for (int v = 0; v < 3; v++) begin
            set_req_a(1, 32'h0000_1234, bad_bytes[v], 5'd3);
            push_a(1, 1'b1, 32'd0, 1'b0);
            ifa.req_i = 4'b0010;
            @(negedge clk);
            chk("inv_gnt", ifa.gnt_o, 32'h2);
            chk("inv_ss_c1", ifa.spi_ss_o, 32'hFFFF_FFFF);
            chk("inv_en_c1", ifa.spi_enable_o, 1'b0);
            @(negedge clk);
            chk("inv_done_c2", ifa.done_o, 32'h2);
            chk("inv_err_c2", ifa.err_o, 1'b1);
            chk("inv_ss_c2", ifa.spi_ss_o, 32'hFFFF_FFFF);
            chk("inv_en_c2", ifa.spi_enable_o, 1'b0);
            ifa.req_i = '0;
            @(negedge clk);
            chk("inv_idle", ifa.busy_o, 1'b0);
        end

        // Reset during XFER, then requester 0 wins over a waiting 3.
        lat_a = 100;
        set_req_a(3, 32'hCAFE_0003, 3'd2, 5'd9);
        ifa.req_i = 4'b1000;
        @(negedge clk);
        chk("rx_gnt", ifa.gnt_o, 32'h8);
        repeat (4) @(negedge clk);
        chk("rx_in_xfer", ifa.spi_enable_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("rx_en_drop", ifa.spi_enable_o, 1'b0);
        chk("rx_ss_idle", ifa.spi_ss_o, 32'hFFFF_FFFF);
        chk("rx_gnt_drop", ifa.gnt_o, 32'd0);
        chk("rx_done_none", ifa.done_o, 32'd0);
        chk("rx_busy_drop", ifa.busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lat_a = 3;
        set_req_a(0, 32'h0000_0A0A, 3'd1, 5'd0);
        push_a(0, 1'b0, 32'h0000_0A0A ^ 32'h0F0F_0F0F, 1'b1);
        push_a(3, 1'b0, 32'hCAFE_0003 ^ 32'h0F0F_0F0F, 1'b1);
        ifa.req_i = 4'b1001;
        @(negedge clk);
        chk("rx_gnt_r0", ifa.gnt_o, 32'h1);
        chk("rx_ss_r0", ifa.spi_ss_o, 32'hFFFF_FFFE);
        run(0, 100, cyc, en);
        ifa.req_i = 4'b1000;
        @(negedge clk);
        chk("rx_gap", ifa.busy_o, 1'b0);
        @(negedge clk);
        chk("rx_gnt_r3", ifa.gnt_o, 32'h8);
        run(0, 100, cyc, en);
        ifa.req_i = '0;
        @(negedge clk);

        // Active-high selects: line 0 asserted across SETUP+XFER+HOLD.
        set_req_b(0, 32'h0BAD_F00D, 3'd3, 5'd0);
        push_b(0, 1'b0, 32'h0BAD_F00D ^ 32'h3C3C_3C3C, 1'b1);
        ifb.req_i = 4'b0001;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp_ss = (c <= 7) ? 32'h1 : 32'h0;
            chk("ah_ss", ifb.spi_ss_o, exp_ss);
            if (c == 1) ifb.req_i = '0;
            if (c == 3) chk("ah_en_c3", ifb.spi_enable_o, 1'b1);
            if (c == 8) chk("ah_done_c8", ifb.done_o, 32'h1);
        end

        // Select index past a 16-line bus is rejected.
        set_req_b(1, 32'h0, 3'd2, 5'd16);
        push_b(1, 1'b1, 32'd0, 1'b0);
        ifb.req_i = 4'b0010;
        @(negedge clk);
        chk("ssr_gnt", ifb.gnt_o, 32'h2);
        chk("ssr_ss_c1", ifb.spi_ss_o, 32'h0);
        @(negedge clk);
        chk("ssr_done", ifb.done_o, 32'h2);
        chk("ssr_ss_c2", ifb.spi_ss_o, 32'h0);
        chk("ssr_en", ifb.spi_enable_o, 1'b0);
        ifb.req_i = '0;
        @(negedge clk);

        // Timeout: master stuck at 2 bytes while 4 are expected.
        stuck_b = 1'b1;
        set_req_b(2, 32'h7777_0000, 3'd4, 5'd3);
        push_b(2, 1'b1, 32'd0, 1'b0);
        ifb.req_i = 4'b0100;
        @(negedge clk);
        chk("to_gnt", ifb.gnt_o, 32'h4);
        chk("to_ss", ifb.spi_ss_o, 32'h8);
        ifb.req_i = '0;
        run(1, 100, cyc, en);
        chk("to_en_cycles", en, 16);
        chk("to_done_cycle", 1 + cyc, 21);
        stuck_b = 1'b0;
        @(negedge clk);
        chk("to_idle", ifb.busy_o, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_a_drained", sb_a.size(), 32'd0);
        chk("sb_b_drained", sb_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
